enc8_3_drain: RTL and testbench

- Sequential 8-to-3 priority encoder that performs the inverse mapping of the 3-to-8 decoder.
- Accepts an 8-bit request vector over a valid/ready handshake.
- Emits the 3-bit index of each set bit, one code per output handshake, highest priority first.
- Sits between request-generating logic and a consumer that needs binary indices, e.g. the dec3_8 feeding back to per-line strobes.

---
 rtl/enc8_3_drain.sv | 135 +++++++++++++
 tb/tb_enc8_3_drain.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enc8_3_drain.sv
// enc8_3_drain: sequential 8-to-3 priority encoder.
// Accepts an 8-bit request vector, then drains it one index per output
// handshake, highest-priority bit first. The priority direction is selected
// by HI_FIRST (1: bit 7 first, 0: bit 0 first).
module enc8_3_drain #(
   parameter bit HI_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] x,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] y,
   output logic       out_last,
   output logic       zero_pulse,
   output logic       busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   logic [0:0] r_state;
   logic [7:0] r_pend;
   logic       r_armed;
   logic       r_zero;

   logic       w_in_drain;
   logic       w_accept;
   logic       w_x_zero;
   logic       w_hshk;
   logic [2:0] w_idx;
   logic       w_one;
   logic [7:0] w_clr_mask;

   // Index of the highest set bit; later (higher) matches overwrite earlier.
   function automatic logic [2:0] f_hi_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = i[2:0];
      end
      return idx;
   endfunction

   // Index of the lowest set bit; scan downward so the lowest match wins.
   function automatic logic [2:0] f_lo_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = i[2:0];
      end
      return idx;
   endfunction

   // True when exactly one bit of v is set (popcount == 1).
   function automatic logic f_one_hot(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'd0, v[i]};
      end
      return (cnt == 4'd1);
   endfunction

   // Handshake qualifiers and next code derived from the pending vector.
   always_comb begin
      w_in_drain = (r_state == S_DRAIN);
      w_accept   = in_valid && r_armed && (r_state == S_IDLE);
      w_x_zero   = (x == 8'h00);
      w_hshk     = w_in_drain && out_ready;
      w_idx      = HI_FIRST ? f_hi_idx(r_pend) : f_lo_idx(r_pend);
      w_one      = f_one_hot(r_pend);
      w_clr_mask = 8'h01 << w_idx;
   end

   // in_ready is held low until the first clock edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= 1'b1;
      end
   end

   // Flag an accepted all-zero vector for exactly one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero <= 1'b0;
      end else begin
         r_zero <= w_accept && w_x_zero;
      end
   end

   // IDLE/DRAIN control: enter DRAIN on a non-zero accept, leave on the last handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && !w_x_zero) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_hshk && w_one) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Pending bits: loaded on accept, one bit retired per output handshake.
   // x is never sampled in DRAIN, so a source changing x there has no effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= 8'h00;
      end else if (w_accept && !w_x_zero) begin
         r_pend <= x;
      end else if (w_hshk) begin
         r_pend <= r_pend & ~w_clr_mask;
      end
   end

   // Outputs are gated by state so IDLE always presents y=0, out_last=0.
   always_comb begin
      in_ready   = r_armed && (r_state == S_IDLE);
      out_valid  = w_in_drain;
      busy       = w_in_drain;
      y          = w_in_drain ? w_idx : 3'd0;
      out_last   = w_in_drain && w_one;
      zero_pulse = r_zero;
   end

endmodule

// File: tb/tb_enc8_3_drain.sv
// Bench for enc8_3_drain: two instances (HI_FIRST=1 and 0) share stimulus.
// A queue-based model predicts every output at each falling edge; handshake
// logs are compared against hand-computed code sequences.
module tb_enc8_3_drain;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] x = 8'h00;
   logic       out_ready = 1'b0;

   logic       in_ready_h, out_valid_h, out_last_h, zero_pulse_h, busy_h;
   logic [2:0] y_h;
   logic       in_ready_l, out_valid_l, out_last_l, zero_pulse_l, busy_l;
   logic [2:0] y_l;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   int q_hi[$];
   int q_lo[$];
   bit m_armed = 1'b0;
   bit m_zp = 1'b0;

   // handshake logs
   int log_hi[$];
   int log_lo[$];
   int last_hi[$];

   always #5 clk = ~clk;

   enc8_3_drain #(.HI_FIRST(1'b1)) u_hi (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .x(x),
      .out_valid(out_valid_h), .out_ready(out_ready), .y(y_h), .out_last(out_last_h),
      .zero_pulse(zero_pulse_h), .busy(busy_h));

   enc8_3_drain #(.HI_FIRST(1'b0)) u_lo (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .x(x),
      .out_valid(out_valid_l), .out_ready(out_ready), .y(y_l), .out_last(out_last_l),
      .zero_pulse(zero_pulse_l), .busy(busy_l));

   task automatic chk(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic chk_seq(input string nm, input int got[$], input int exp[$]);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %p expected %p", nm, got, exp);
      end
   endtask

   // Model: a vector becomes a list of indices in priority order; each
   // handshake removes the head; the list being non-empty means DRAIN.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q_hi.delete();
         q_lo.delete();
         m_armed = 1'b0;
         m_zp = 1'b0;
      end else begin
         automatic bit acc = (q_hi.size() == 0) && m_armed && in_valid;
         if (q_hi.size() > 0 && out_ready) begin
            void'(q_hi.pop_front());
            void'(q_lo.pop_front());
         end
         m_zp = acc && (x == 8'h00);
         if (acc && x != 8'h00) begin
            for (int b = 7; b >= 0; b--) if (x[b]) q_hi.push_back(b);
            for (int b = 0; b <= 7; b++) if (x[b]) q_lo.push_back(b);
         end
         m_armed = 1'b1;
      end
   end

   // Compare process: every falling edge, both instances against the model.
   always @(negedge clk) begin
      automatic bit ov = (q_hi.size() > 0);
      chk("hi_out_valid", out_valid_h, ov);
      chk("hi_busy", busy_h, ov);
      chk("hi_y", y_h, ov ? q_hi[0] : 0);
      chk("hi_out_last", out_last_h, q_hi.size() == 1);
      chk("hi_in_ready", in_ready_h, m_armed && !ov);
      chk("hi_zero_pulse", zero_pulse_h, m_zp);
      chk("lo_out_valid", out_valid_l, ov);
      chk("lo_busy", busy_l, ov);
      chk("lo_y", y_l, ov ? q_lo[0] : 0);
      chk("lo_out_last", out_last_l, q_lo.size() == 1);
      chk("lo_in_ready", in_ready_l, m_armed && !ov);
      chk("lo_zero_pulse", zero_pulse_l, m_zp);
      if (!rst && out_valid_h && out_ready) begin
         log_hi.push_back(int'(y_h));
         last_hi.push_back(int'(out_last_h));
      end
      if (!rst && out_valid_l && out_ready) log_lo.push_back(int'(y_l));
   end

   task automatic clear_logs();
      log_hi.delete();
      log_lo.delete();
      last_hi.delete();
   endtask

   // Present v until accepted (bounded), then drop in_valid.
   task automatic send(input logic [7:0] v);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      x = v;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (in_ready_h) begin
            @(posedge clk);
            #2;
            in_valid = 1'b0;
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         in_valid = 1'b0;
         chk("send_timeout", 0, 1);
      end
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         if (q_hi.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #2;
   endtask

   initial begin
      int exp_q[$];
      int exp_l[$];

      // reset hold and release
      repeat (3) @(posedge clk);
      #2;
      chk("rst_in_ready_held", in_ready_h, 0);
      chk("rst_out_valid", out_valid_h, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_before_edge", in_ready_h, 0);
      @(posedge clk);
      #1;
      chk("in_ready_after_edge", in_ready_h, 1);
      #1;

      // A4, out_ready held high
      out_ready = 1'b1;
      clear_logs();
      send(8'b1010_0100);
      wait_drain();
      exp_q = '{7, 5, 2}; chk_seq("a4_hi_codes", log_hi, exp_q);
      exp_l = '{0, 0, 1}; chk_seq("a4_hi_last", last_hi, exp_l);
      exp_q = '{2, 5, 7}; chk_seq("a4_lo_codes", log_lo, exp_q);
      chk("a4_in_ready_after", in_ready_h, 1);

      // FF with out_ready toggling 1,0,1,0...
      clear_logs();
      send(8'hFF);
      for (int i = 0; i < 20; i++) begin
         out_ready = (i % 2 == 0);
         @(posedge clk);
         #2;
      end
      out_ready = 1'b1;
      wait_drain();
      exp_q = '{7, 6, 5, 4, 3, 2, 1, 0}; chk_seq("ff_hi_codes", log_hi, exp_q);
      exp_q = '{0, 1, 2, 3, 4, 5, 6, 7}; chk_seq("ff_lo_codes", log_lo, exp_q);
      chk("ff_handshakes", log_hi.size(), 8);

      // all-zero vector
      clear_logs();
      send(8'h00);
      @(negedge clk);
      chk("zero_pulse_high", zero_pulse_h, 1);
      chk("zero_out_valid", out_valid_h, 0);
      chk("zero_in_ready", in_ready_h, 1);
      @(negedge clk);
      chk("zero_pulse_low", zero_pulse_h, 0);
      @(posedge clk);
      #2;

      // 81 pending, 10 presented during DRAIN is ignored until IDLE
      clear_logs();
      send(8'h81);
      send(8'h10);
      wait_drain();
      exp_q = '{7, 0, 4}; chk_seq("ovl_hi_codes", log_hi, exp_q);
      exp_l = '{0, 1, 1}; chk_seq("ovl_hi_last", last_hi, exp_l);
      exp_q = '{0, 7, 4}; chk_seq("ovl_lo_codes", log_lo, exp_q);

      // F0, reset after first handshake
      clear_logs();
      send(8'hF0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid_h, 0);
      chk("mid_rst_busy", busy_h, 0);
      chk("mid_rst_y", y_h, 0);
      chk("mid_rst_in_ready", in_ready_h, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("post_rst_in_ready", in_ready_h, 1);
      chk("post_rst_out_valid", out_valid_h, 0);
      exp_q = '{7}; chk_seq("rst_hi_codes", log_hi, exp_q);
      exp_q = '{4}; chk_seq("rst_lo_codes", log_lo, exp_q);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
